// File: rtl/usb_rx_pkg.sv
// ---------------------------------------------------------------------------
// usb_rx_pkg
// Shared constants and types for the full-speed USB receive decode chain:
// PID values, SYNC line pattern, CRC16 parameters, line-state and FSM enums.
// ---------------------------------------------------------------------------
package usb_rx_pkg;

    // Packet identifiers (as received, LSB first)
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;

    // Line state encoding is {DP, DM}
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_t;

    // K J K J K J K K, oldest sample in the top two bits
    localparam logic [15:0] SYNC_PATTERN = 16'b01_10_01_10_01_10_01_01;

    // Serial CRC16, bit stream fed in arrival order
    localparam logic [15:0] CRC16_POLY    = 16'h8005;
    localparam logic [15:0] CRC16_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC16_RESIDUE = 16'h800D;

    // Unstuffed bit counts, PID included
    localparam logic [7:0] LEN_PID         = 8'd8;
    localparam logic [7:0] LEN_PAYLOAD_END = 8'd72;
    localparam logic [7:0] LEN_DATA0       = 8'd88;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SYNC_HUNT = 3'd1,
        ST_RECEIVE   = 3'd2,
        ST_EOP1      = 3'd3,
        ST_EOP2      = 3'd4
    } rx_state_t;

    // Upper nibble of a PID is the complement of the lower nibble
    function automatic logic pid_check_ok(input logic [7:0] pid);
        return pid[7:4] == ~pid[3:0];
    endfunction

endpackage

// File: rtl/usb_rx_decode_crc16.sv
// ---------------------------------------------------------------------------
// crc16_check
// Serial CRC16 register with residue compare.
//   clock, reset_n : bit clock, async active-low reset
//   clear          : reload the register with the initial value
//   in_bit         : next data bit (arrival order)
//   enable         : in_bit is valid this cycle
//   ok             : register currently holds the good-packet residue
// ---------------------------------------------------------------------------
module crc16_check
    import usb_rx_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic in_bit,
    input  logic enable,
    output logic ok
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic        feedback;

    always_comb begin
        crc_d    = crc_q;
        feedback = crc_q[15] ^ in_bit;
        if (clear) begin
            crc_d = CRC16_INIT;
        end else if (enable) begin
            crc_d = {crc_q[14:0], 1'b0} ^ (feedback ? CRC16_POLY : 16'h0000);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC16_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign ok = (crc_q == CRC16_RESIDUE);

endmodule

// File: rtl/usb_rx_decode.sv
// ---------------------------------------------------------------------------
// usb_rx_decode
// Full-speed USB receive decode: SYNC hunt, NRZI decode, bit unstuffing,
// PID check, CRC16 check and packet classification (ACK, NAK, DATA0).
//   clock, reset_n : bit-rate clock, async active-low reset
//   DP_in, DM_in   : line pair, X/Z read as 0
//   host_sending   : host owns the bus; receiver held idle
//   out_bit        : unstuffed post-PID bit, valid with crc_sending
//   crc_sending    : out_bit valid (3 cycles after the carrying sample)
//   ACK_rec, NAK_rec, DATA0_rec, rx_error : one-cycle result pulses
//   crc_valid      : last data packet had a good CRC (held)
//   data0          : last good DATA0 payload, first bit at [0] (held)
// ---------------------------------------------------------------------------
module usb_rx_decode
    import usb_rx_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        DP_in,
    input  logic        DM_in,
    input  logic        host_sending,
    output logic        out_bit,
    output logic        crc_sending,
    output logic        ACK_rec,
    output logic        NAK_rec,
    output logic        DATA0_rec,
    output logic        crc_valid,
    output logic [63:0] data0,
    output logic        rx_error
);

    logic        dp_s;
    logic        dm_s;
    line_t       line_s;

    rx_state_t   state_q,     state_d;
    logic [15:0] hist_q,      hist_d;
    line_t       prev_q,      prev_d;
    logic [2:0]  ones_q,      ones_d;
    logic [7:0]  cnt_q,       cnt_d;
    logic [7:0]  pid_q,       pid_d;
    logic [63:0] shift_q,     shift_d;
    logic [2:0]  pipe_v_q,    pipe_v_d;
    logic [2:0]  pipe_b_q,    pipe_b_d;
    logic        out_bit_q,   out_bit_d;
    logic        crc_send_q,  crc_send_d;
    logic        ack_q,       ack_d;
    logic        nak_q,       nak_d;
    logic        d0_rec_q,    d0_rec_d;
    logic        rx_error_q,  rx_error_d;
    logic        crc_valid_q, crc_valid_d;
    logic [63:0] data0_q,     data0_d;

    logic [15:0] hist_shift;
    logic        nrzi_bit;
    logic [7:0]  pid_next;
    logic        err;
    logic        crc_clear;
    logic        crc_en;
    logic        crc_ok;

    // Undriven or unknown line pins must never look like a J or K
    assign dp_s   = (DP_in === 1'b1);
    assign dm_s   = (DM_in === 1'b1);
    assign line_s = line_t'({dp_s, dm_s});

    assign hist_shift = {hist_q[13:0], line_s};
    assign nrzi_bit   = (line_s == prev_q);
    assign pid_next   = {nrzi_bit, pid_q[7:1]};

    crc16_check u_crc16 (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (crc_clear),
        .in_bit  (nrzi_bit),
        .enable  (crc_en),
        .ok      (crc_ok)
    );

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        prev_d      = prev_q;
        ones_d      = ones_q;
        cnt_d       = cnt_q;
        pid_d       = pid_q;
        shift_d     = shift_q;
        crc_valid_d = crc_valid_q;
        data0_d     = data0_q;
        ack_d       = 1'b0;
        nak_d       = 1'b0;
        d0_rec_d    = 1'b0;
        err         = 1'b0;
        crc_clear   = 1'b0;
        crc_en      = 1'b0;

        // Output delay line: a bit enters stage 0 on its sample edge
        pipe_v_d   = {pipe_v_q[1:0], 1'b0};
        pipe_b_d   = {pipe_b_q[1:0], 1'b0};
        crc_send_d = pipe_v_q[2];
        out_bit_d  = pipe_b_q[2];

        case (state_q)
            ST_IDLE: begin
                hist_d  = hist_shift;
                state_d = ST_SYNC_HUNT;
            end

            ST_SYNC_HUNT: begin
                hist_d = hist_shift;
                if (hist_shift == SYNC_PATTERN) begin
                    state_d     = ST_RECEIVE;
                    hist_d      = '0;
                    prev_d      = LS_K;
                    ones_d      = 3'd0;
                    cnt_d       = 8'd0;
                    crc_valid_d = 1'b0;
                    crc_clear   = 1'b1;
                end
            end

            ST_RECEIVE: begin
                case (line_s)
                    LS_SE1: err = 1'b1;
                    LS_SE0: begin
                        if (cnt_q[2:0] != 3'd0) begin
                            err = 1'b1;
                        end else begin
                            state_d = ST_EOP1;
                        end
                    end
                    default: begin
                        prev_d = line_s;
                        if (ones_q == 3'd6) begin
                            // Stuffed position: must be a 0, and is dropped
                            if (nrzi_bit) begin
                                err = 1'b1;
                            end else begin
                                ones_d = 3'd0;
                            end
                        end else begin
                            ones_d = nrzi_bit ? ones_q + 3'd1 : 3'd0;
                            cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                            if (cnt_q < LEN_PID) begin
                                pid_d = pid_next;
                                if ((cnt_q == LEN_PID - 8'd1) && !pid_check_ok(pid_next)) begin
                                    err = 1'b1;
                                end
                            end else begin
                                crc_en      = 1'b1;
                                pipe_v_d[0] = 1'b1;
                                pipe_b_d[0] = nrzi_bit;
                                if (cnt_q < LEN_PAYLOAD_END) begin
                                    shift_d = {nrzi_bit, shift_q[63:1]};
                                end
                            end
                        end
                    end
                endcase
            end

            ST_EOP1: begin
                if (line_s == LS_SE0) begin
                    state_d = ST_EOP2;
                end else begin
                    err = 1'b1;
                end
            end

            ST_EOP2: begin
                if (line_s == LS_J) begin
                    state_d = ST_IDLE;
                    case (pid_q)
                        PID_ACK: begin
                            if (cnt_q == LEN_PID) ack_d = 1'b1;
                            else                  err   = 1'b1;
                        end
                        PID_NAK: begin
                            if (cnt_q == LEN_PID) nak_d = 1'b1;
                            else                  err   = 1'b1;
                        end
                        PID_DATA0: begin
                            if ((cnt_q == LEN_DATA0) && crc_ok) begin
                                crc_valid_d = 1'b1;
                                d0_rec_d    = 1'b1;
                                data0_d     = shift_q;
                            end else begin
                                crc_valid_d = 1'b0;
                                err         = 1'b1;
                            end
                        end
                        default: err = 1'b1;
                    endcase
                end else begin
                    err = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (err) begin
            state_d = ST_IDLE;
        end
        rx_error_d = err;

        // Host owns the bus: drop any packet in flight, keep held results
        if (host_sending) begin
            state_d     = ST_IDLE;
            hist_d      = '0;
            ack_d       = 1'b0;
            nak_d       = 1'b0;
            d0_rec_d    = 1'b0;
            rx_error_d  = 1'b0;
            crc_valid_d = crc_valid_q;
            data0_d     = data0_q;
            pipe_v_d[0] = 1'b0;
            pipe_b_d[0] = 1'b0;
            crc_en      = 1'b0;
            crc_clear   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hist_q      <= '0;
            prev_q      <= LS_SE0;
            ones_q      <= '0;
            cnt_q       <= '0;
            pid_q       <= '0;
            shift_q     <= '0;
            pipe_v_q    <= '0;
            pipe_b_q    <= '0;
            out_bit_q   <= 1'b0;
            crc_send_q  <= 1'b0;
            ack_q       <= 1'b0;
            nak_q       <= 1'b0;
            d0_rec_q    <= 1'b0;
            rx_error_q  <= 1'b0;
            crc_valid_q <= 1'b0;
            data0_q     <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            prev_q      <= prev_d;
            ones_q      <= ones_d;
            cnt_q       <= cnt_d;
            pid_q       <= pid_d;
            shift_q     <= shift_d;
            pipe_v_q    <= pipe_v_d;
            pipe_b_q    <= pipe_b_d;
            out_bit_q   <= out_bit_d;
            crc_send_q  <= crc_send_d;
            ack_q       <= ack_d;
            nak_q       <= nak_d;
            d0_rec_q    <= d0_rec_d;
            rx_error_q  <= rx_error_d;
            crc_valid_q <= crc_valid_d;
            data0_q     <= data0_d;
        end
    end

    assign out_bit     = out_bit_q;
    assign crc_sending = crc_send_q;
    assign ACK_rec     = ack_q;
    assign NAK_rec     = nak_q;
    assign DATA0_rec   = d0_rec_q;
    assign rx_error    = rx_error_q;
    assign crc_valid   = crc_valid_q;
    assign data0       = data0_q;

endmodule

// File: tb/tb_usb_rx_decode.sv
// ---------------------------------------------------------------------------
// tb_usb_rx_decode
// Self-checking bench for usb_rx_decode. Packets are NRZI-encoded and
// bit-stuffed here; expected out_bit values and result pulses are queued
// with their due cycle and compared as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_usb_rx_decode;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        DP_in = 1'b1;
    logic        DM_in = 1'b0;
    logic        host_sending = 1'b0;
    logic        out_bit;
    logic        crc_sending;
    logic        ACK_rec;
    logic        NAK_rec;
    logic        DATA0_rec;
    logic        crc_valid;
    logic [63:0] data0;
    logic        rx_error;

    usb_rx_decode dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .DP_in        (DP_in),
        .DM_in        (DM_in),
        .host_sending (host_sending),
        .out_bit      (out_bit),
        .crc_sending  (crc_sending),
        .ACK_rec      (ACK_rec),
        .NAK_rec      (NAK_rec),
        .DATA0_rec    (DATA0_rec),
        .crc_valid    (crc_valid),
        .data0        (data0),
        .rx_error     (rx_error)
    );

    always #5 clock = ~clock;

    localparam logic [3:0] K_ACK = 4'b1000;
    localparam logic [3:0] K_NAK = 4'b0100;
    localparam logic [3:0] K_D0  = 4'b0010;
    localparam logic [3:0] K_ERR = 4'b0001;
    localparam logic [3:0] K_NONE = 4'b0000;

    typedef struct { int cyc; logic b; } out_exp_t;
    typedef struct { int cyc; logic [3:0] kind; } pulse_exp_t;

    out_exp_t   outq[$];
    pulse_exp_t pulseq[$];

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic line_dp = 1'b1;
    int   ones_tb = 0;
    bit   stuff_en = 1'b1;
    logic [63:0] exp_data0 = '0;
    logic        exp_crc_valid = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: one pass per clock, 1 time unit after the edge
    initial forever begin
        logic [3:0] obs;
        @(posedge clock);
        cyc++;
        #1;
        if (crc_sending) begin
            if (outq.size() == 0) begin
                check_val("out_extra", 64'(crc_sending), 64'(0));
            end else begin
                out_exp_t e;
                e = outq.pop_front();
                check_val("out_cycle", 64'(cyc), 64'(e.cyc));
                check_val("out_bit", 64'(out_bit), 64'(e.b));
            end
        end else if (outq.size() > 0 && outq[0].cyc <= cyc) begin
            check_val("out_missing", 64'(crc_sending), 64'(1));
            void'(outq.pop_front());
        end
        obs = {ACK_rec, NAK_rec, DATA0_rec, rx_error};
        if (obs != K_NONE) begin
            if (pulseq.size() == 0) begin
                check_val("pulse_extra", 64'(obs), 64'(K_NONE));
            end else begin
                pulse_exp_t p;
                p = pulseq.pop_front();
                check_val("pulse_cycle", 64'(cyc), 64'(p.cyc));
                check_val("pulse_kind", 64'(obs), 64'(p.kind));
            end
        end else if (pulseq.size() > 0 && pulseq[0].cyc <= cyc) begin
            check_val("pulse_missing", 64'(obs), 64'(pulseq[0].kind));
            void'(pulseq.pop_front());
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Reference CRC16 over a 64-bit payload, bit 0 first
    function automatic logic [15:0] crc16_model(input logic [63:0] d);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 64; i++) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
        end
        return c;
    endfunction

    task automatic drive(input logic dp, input logic dm);
        @(negedge clock);
        DP_in = dp;
        DM_in = dm;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0);
        line_dp = 1'b1;
    endtask

    task automatic send_sync();
        logic [7:0] s;
        s = 8'b01010100;
        for (int i = 7; i >= 0; i--) drive(s[i], ~s[i]);
        line_dp = 1'b0;
        ones_tb = 0;
    endtask

    // NRZI-encode one data bit, queue it if it is a post-PID bit,
    // then insert a stuffed 0 after six consecutive ones
    task automatic send_bit(input logic b, input bit post);
        if (!b) line_dp = ~line_dp;
        drive(line_dp, ~line_dp);
        if (post) outq.push_back('{cyc + 4, b});
        if (b) ones_tb++;
        else   ones_tb = 0;
        if (stuff_en && ones_tb == 6) begin
            line_dp = ~line_dp;
            drive(line_dp, ~line_dp);
            ones_tb = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v, input bit post);
        for (int i = 0; i < 8; i++) send_bit(v[i], post);
    endtask

    task automatic send_eop(input logic [3:0] kind);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        if (kind != K_NONE) pulseq.push_back('{cyc + 1, kind});
        idle(3);
    endtask

    task automatic send_data0(input logic [63:0] d, input logic [15:0] flip, input logic [3:0] kind);
        logic [15:0] tx;
        send_sync();
        send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 64; i++) send_bit(d[i], 1'b1);
        tx = ~crc16_model(d) ^ flip;
        for (int i = 15; i >= 0; i--) send_bit(tx[i], 1'b1);
        send_eop(kind);
    endtask

    task automatic check_held(input string tag);
        check_val({tag, "_crc_valid"}, 64'(crc_valid), 64'(exp_crc_valid));
        check_val({tag, "_data0"}, data0, exp_data0);
    endtask

    initial begin
        logic [7:0] badpid;

        // Reset state
        idle(3);
        check_val("rst_out_bit", 64'(out_bit), 64'(0));
        check_val("rst_crc_sending", 64'(crc_sending), 64'(0));
        check_val("rst_pulses", 64'({ACK_rec, NAK_rec, DATA0_rec, rx_error}), 64'(0));
        check_held("rst");
        reset_n = 1'b1;
        idle(4);

        // Handshakes
        send_sync(); send_byte(8'h5A, 1'b0); send_eop(K_NAK);
        send_sync(); send_byte(8'hD2, 1'b0); send_eop(K_ACK);
        check_held("after_hs");

        // Good DATA0 packets, the second one full of stuffed bits
        send_data0(64'h0123456789ABCDEF, 16'h0000, K_D0);
        exp_data0 = 64'h0123456789ABCDEF; exp_crc_valid = 1'b1;
        check_held("data0_a");
        send_data0({64{1'b1}}, 16'h0000, K_D0);
        exp_data0 = {64{1'b1}};
        check_held("data0_ff");

        // Corrupted CRC bit
        send_data0(64'hDEADBEEF00C0FFEE, 16'h0004, K_ERR);
        exp_crc_valid = 1'b0;
        check_held("bad_crc");

        send_data0(64'h0123456789ABCDEF, 16'h0000, K_D0);
        exp_data0 = 64'h0123456789ABCDEF; exp_crc_valid = 1'b1;
        check_held("data0_b");

        // Host owns the bus during a valid NAK: nothing may happen
        @(negedge clock); host_sending = 1'b1;
        send_sync(); send_byte(8'h5A, 1'b0); send_eop(K_NONE);
        @(negedge clock); host_sending = 1'b0;
        idle(2);
        check_held("host_abort");

        // Seven ones in a row after the PID's trailing ones
        stuff_en = 1'b0;
        send_sync(); send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        pulseq.push_back('{cyc + 1, K_ERR});
        stuff_en = 1'b1;
        send_eop(K_NONE);
        exp_crc_valid = 1'b0;
        check_held("stuff_err");

        // PID check nibble wrong: flagged on the eighth PID bit
        badpid = 8'hC2;
        send_sync();
        for (int i = 0; i < 8; i++) send_bit(badpid[i], 1'b0);
        pulseq.push_back('{cyc + 1, K_ERR});
        send_eop(K_NONE);

        // Well-formed but unknown PID: flagged at EOP
        send_sync(); send_byte(8'hE1, 1'b0); send_eop(K_ERR);

        // ACK followed by a byte: wrong length
        send_sync(); send_byte(8'hD2, 1'b0); send_byte(8'h00, 1'b1); send_eop(K_ERR);

        // NAK plus three bits: SE0 on a non-byte boundary
        send_sync(); send_byte(8'h5A, 1'b0);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        pulseq.push_back('{cyc + 1, K_ERR});
        drive(1'b0, 1'b0);
        idle(3);
        check_held("len_err");

        // Reset in the middle of a DATA0 payload
        send_sync(); send_byte(8'hC3, 1'b0);
        for (int i = 0; i < 30; i++) send_bit(i[0], 1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        outq.delete();
        idle(2);
        exp_data0 = '0; exp_crc_valid = 1'b0;
        check_val("midrst_crc_sending", 64'(crc_sending), 64'(0));
        check_val("midrst_out_bit", 64'(out_bit), 64'(0));
        check_held("midrst");
        reset_n = 1'b1;
        idle(3);
        send_sync(); send_byte(8'h5A, 1'b0); send_eop(K_NAK);
        send_data0(64'hA5A5_0F0F_FFFF_0001, 16'h0000, K_D0);
        exp_data0 = 64'hA5A5_0F0F_FFFF_0001; exp_crc_valid = 1'b1;
        check_held("after_rst");

        idle(8);
        check_val("outq_drained", 64'(outq.size()), 64'(0));
        check_val("pulseq_drained", 64'(pulseq.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
